mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped console responder on the core's data-memory bus: the core initiates stores and loads; this block answers them.
- A store of a byte to the TX data address is queued in a small FIFO, then serialised on a UART 8N1 line.
- Status and divisor registers are readable through the same bus.
- Sits beside the DRAM on the MEM-stage bus; gives the core a real character output instead of a probed memory word.

Parameters:
- FIFO_DEPTH, 8, TX byte queue depth; power of 2; 2..8.
- DIV_RESET, 16, clocks per UART bit after reset.
- DATA_ADDR, 8'hFF, word address of TXDATA (write-only).
- STAT_ADDR, 8'hFE, word address of STATUS (read; W1C bit 3).
- DIV_ADDR, 8'hFD, word address of DIVISOR (read/write, 16 bits).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- clear  in  1  reset; synchronous, active-high.
- addr  in  8  word address from the MEM-stage ALU result [7:0].
- wdata  in  32  store data.
- wren  in  1  store strobe, one cycle per store.
- rdata  out  32  registered read data for addr.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high while the serialiser is not IDLE.

Behaviour:
- Reset (clear=1 at an edge): tx=1, busy=0, rdata=0, FSM=IDLE, FIFO empty, overflow=0, divisor=DIV_RESET.
- Reset mid-frame aborts the frame: tx is 1 after that edge, and queued bytes are discarded.
- Reads:
  - rdata is registered and updated every edge from addr (no read strobe).
  - STAT_ADDR returns: bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits[7:4] count, rest 0.
  - DIV_ADDR returns {16'b0, divisor}.
  - DATA_ADDR and any unmapped address return 0.
- Writes (wren=1):
  - DATA_ADDR pushes wdata[7:0]; wdata[31:8] is ignored.
  - DIV_ADDR loads wdata[15:0]; a value of 0 is stored as 1.
  - STAT_ADDR with wdata[3]=1 clears overflow.
  - Unmapped addresses are ignored.
- FIFO:
  - count 0..FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0).
  - A push while full with no simultaneous pop is dropped and sets overflow (sticky until W1C or reset).
  - A push while full with a pop in the same cycle is accepted; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: if not empty, pop into a shift register, latch divisor into bit_div, go to START; tx=0 after that edge.
  - START: tx=0 for bit_div cycles, then DATA.
  - DATA: 8 bits, LSB first, each held bit_div cycles; a 3-bit index tracks the bit.
  - STOP: tx=1 for bit_div cycles. On the last cycle, if not empty, pop and go to START (back-to-back frames); otherwise go to IDLE.
  - Frame length is exactly 10*bit_div cycles.
  - A divisor write mid-frame takes effect at the next frame start only.
- Latency: a push sampled at edge E makes the FIFO non-empty after E. If IDLE, tx falls after edge E+1.
- busy = (state != IDLE), registered. It rises with the START transition and falls on entry to IDLE.

Decomposition:
- Package uart_mmio_pkg holds:
  - the default address constants;
  - STATUS bit indices (BUSY=0, FULL=1, EMPTY=2, OVF=3, COUNT=7:4);
  - the serialiser state encoding (2-bit IDLE/START/DATA/STOP).
- Sub-module byte_fifo (parameter DEPTH): synchronous 8-bit FIFO with push, pop, dout, count, full and empty. Its reset port is clear, synchronous and active-high.
- The top level holds register decode, read mux, the divisor/overflow registers and the serialiser FSM with its bit counter.

Test Plan:
- Reset, then read STAT_ADDR → rdata=32'h4 (empty only); read DIV_ADDR → 16; tx=1, busy=0.
- Write DIV_ADDR=4, then write DATA_ADDR=32'h141 → tx low one edge after the push edge for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop high 4 cycles; 40-cycle frame; busy=0 afterwards.
- With divisor 1, push 3 bytes on consecutive cycles → three frames back-to-back with no idle gap. Mid-run STATUS count reads 2 then 1; empty=1 before the last frame ends.
- With divisor 100, push 10 bytes → the first pops immediately and 8 queue (full=1). The 10th is dropped with overflow=1 and STATUS reads 32'h8B. Writing STAT_ADDR=32'h8 clears overflow; frames 1-9 are sent intact.
- Write DIV_ADDR=0 → reads back 1. Write DIV_ADDR=8 mid-frame at divisor 4 → current frame stays 40 cycles; next frame is 80.
- Assert clear for one cycle during DATA → tx=1 and busy=0 next cycle; FIFO empty; no further frames; divisor back to 16.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_pkg
// Description : Shared constants for the memory-mapped UART transmitter:
//               default register addresses, STATUS bit positions and the
//               serialiser state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_mmio_pkg;

    // Default word addresses of the three registers
    localparam logic [7:0] DATA_ADDR_DEF = 8'hFF;
    localparam logic [7:0] STAT_ADDR_DEF = 8'hFE;
    localparam logic [7:0] DIV_ADDR_DEF  = 8'hFD;

    // STATUS register bit positions
    localparam int STAT_BUSY   = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_HI = 7;

    // Serialiser states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous 8-bit FIFO. A push while full is accepted only
//               when a pop happens in the same cycle. Pops while empty are
//               ignored. dout shows the head entry whenever not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [3:0] count,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic             accept;
    logic             pop_ok;

    assign full  = (count_q == 4'(DEPTH));
    assign empty = (count_q == 4'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrapping by width) and occupancy
    always_comb begin
        pop_ok   = pop && !empty;
        accept   = push && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop_ok})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped console transmitter. Stores to TXDATA queue a
//               byte which is sent as UART 8N1; STATUS and DIVISOR are
//               readable through a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import uart_mmio_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET = 16'd16,
    parameter logic [7:0] DATA_ADDR  = DATA_ADDR_DEF,
    parameter logic [7:0] STAT_ADDR  = STAT_ADDR_DEF,
    parameter logic [7:0] DIV_ADDR   = DIV_ADDR_DEF
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wren,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    tx_state_e   state_q, state_d;
    logic [15:0] divisor_q, divisor_d;
    logic [15:0] bit_div_q, bit_div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_data, wr_div, wr_stat;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic [3:0]  fifo_count;
    logic        fifo_full, fifo_empty;
    logic        cnt_last;
    logic        start_frame;
    logic [15:0] unused_wdata;

    assign unused_wdata = wdata[31:16];

    assign wr_data = wren && (addr == DATA_ADDR);
    assign wr_div  = wren && (addr == DIV_ADDR);
    assign wr_stat = wren && (addr == STAT_ADDR);

    assign rdata = rdata_q;
    assign tx    = tx_q;
    assign busy  = busy_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serialiser next-state: bit timing, frame sequencing and FIFO pop
    always_comb begin
        state_d     = state_q;
        bit_div_d   = bit_div_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        start_frame = 1'b0;
        cnt_last    = (cnt_q == bit_div_q - 16'd1);
        case (state_q)
            ST_IDLE: begin
                start_frame = !fifo_empty;
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
        // The divisor in force now is frozen for the whole new frame
        if (start_frame) begin
            shift_d   = fifo_dout;
            bit_div_d = divisor_q;
            cnt_d     = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_START;
        end
        fifo_pop = start_frame;
    end

    // Register writes, overflow tracking and the read mux
    always_comb begin
        divisor_d = divisor_q;
        ovf_d     = ovf_q;
        rdata_d   = '0;
        if (wr_div) begin
            divisor_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
        end
        if (wr_stat && wdata[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_data && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
        if (addr == STAT_ADDR) begin
            rdata_d[STAT_BUSY]                = busy_q;
            rdata_d[STAT_FULL]                = fifo_full;
            rdata_d[STAT_EMPTY]               = fifo_empty;
            rdata_d[STAT_OVF]                 = ovf_q;
            rdata_d[STAT_CNT_HI:STAT_CNT_LO]  = fifo_count;
        end else if (addr == DIV_ADDR) begin
            rdata_d = {16'd0, divisor_q};
        end
    end

    // All state registers with synchronous active-high clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            divisor_q <= DIV_RESET;
            bit_div_q <= DIV_RESET;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            bit_div_q <= bit_div_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx. A frame-level model
//               (byte queue plus frame start time) predicts tx, busy and
//               rdata every cycle; directed scenarios and a random phase
//               drive the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        clear;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (16'd16),
        .DATA_ADDR  (8'hFF),
        .STAT_ADDR  (8'hFE),
        .DIV_ADDR   (8'hFD)
    ) dut (
        .clock (clock),
        .clear (clear),
        .addr  (addr),
        .wdata (wdata),
        .wren  (wren),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    // Reference model: pending bytes, the frame on the wire and registers
    logic [7:0]  mq[$];
    bit          m_active;
    int          m_fstart;
    int          m_fdiv;
    logic [7:0]  m_fbyte;
    int          m_div;
    bit          m_ovf;
    logic [31:0] m_rdata;
    int          cyc = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Line level implied by elapsed time within the current frame
    function automatic logic exp_tx();
        int k;
        int b;
        if (!m_active) return 1'b1;
        k = cyc - m_fstart;
        b = k / m_fdiv;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_fbyte[b-1];
        return 1'b1;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        int  sz;
        bit  start;
        if (clear) begin
            mq.delete();
            m_active = 0;
            m_ovf    = 0;
            m_div    = 16;
            m_rdata  = '0;
            return;
        end
        sz = mq.size();
        if (addr == 8'hFE)
            m_rdata = {24'd0, 4'(sz), m_ovf, (sz == 0), (sz == DEPTH), m_active};
        else if (addr == 8'hFD)
            m_rdata = 32'(m_div);
        else
            m_rdata = '0;
        start = 0;
        if (!m_active) begin
            start = (sz > 0);
        end else if (cyc - m_fstart == 10 * m_fdiv) begin
            if (sz > 0) start = 1;
            else        m_active = 0;
        end
        if (start) begin
            m_fbyte  = mq.pop_front();
            m_fstart = cyc;
            m_fdiv   = m_div;
            m_active = 1;
        end
        if (wren) begin
            if (addr == 8'hFF) begin
                if (sz < DEPTH || start) mq.push_back(wdata[7:0]);
                else                     m_ovf = 1;
            end else if (addr == 8'hFD) begin
                m_div = (wdata[15:0] == 16'd0) ? 1 : int'(wdata[15:0]);
            end else if (addr == 8'hFE) begin
                if (wdata[3]) m_ovf = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        check("tx", 32'(tx), 32'(exp_tx()));
        check("busy", 32'(busy), 32'(m_active));
        check("rdata", rdata, m_rdata);
    endtask

    task automatic op(input logic w, input logic [7:0] a, input logic [31:0] d, input logic c);
        wren  = w;
        addr  = a;
        wdata = d;
        clear = c;
        tick();
    endtask

    function automatic logic [7:0] pick_addr();
        int r;
        r = $urandom_range(0, 3);
        case (r)
            0:       return 8'hFD;
            1:       return 8'hFE;
            2:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, pick_addr(), $urandom, 1'b0);
    endtask

    initial begin
        int          r;
        logic [31:0] rv;
        wren  = 1'b0;
        addr  = 8'h00;
        wdata = '0;
        clear = 1'b1;

        // Reset and register defaults
        for (int i = 0; i < 3; i++) op(1'b0, 8'h00, 32'h0, 1'b1);
        op(1'b0, 8'hFE, 32'h0, 1'b0);
        check("reset_status", rdata, 32'h4);
        op(1'b0, 8'hFD, 32'h0, 1'b0);
        check("reset_div", rdata, 32'd16);

        // Single frame at divisor 4
        op(1'b1, 8'hFD, 32'd4, 1'b0);
        op(1'b1, 8'hFF, 32'h141, 1'b0);
        idle(50);

        // Back-to-back frames at divisor 1
        op(1'b1, 8'hFD, 32'd1, 1'b0);
        for (int i = 0; i < 3; i++) op(1'b1, 8'hFF, $urandom, 1'b0);
        idle(40);

        // Overflow at divisor 100
        op(1'b1, 8'hFD, 32'd100, 1'b0);
        for (int i = 0; i < 10; i++) op(1'b1, 8'hFF, $urandom, 1'b0);
        op(1'b0, 8'hFE, 32'h0, 1'b0);
        check("ovf_status", rdata, 32'h8B);
        op(1'b1, 8'hFE, 32'h8, 1'b0);
        idle(9100);

        // Divisor zero reads back as one; mid-frame divisor change
        op(1'b1, 8'hFD, 32'd0, 1'b0);
        op(1'b0, 8'hFD, 32'h0, 1'b0);
        check("div_zero", rdata, 32'd1);
        op(1'b1, 8'hFD, 32'd4, 1'b0);
        op(1'b1, 8'hFF, $urandom, 1'b0);
        op(1'b1, 8'hFF, $urandom, 1'b0);
        idle(10);
        op(1'b1, 8'hFD, 32'd8, 1'b0);
        idle(150);

        // Reset during the data bits
        op(1'b1, 8'hFD, 32'd4, 1'b0);
        op(1'b1, 8'hFF, 32'h5A, 1'b0);
        op(1'b1, 8'hFF, 32'hC3, 1'b0);
        idle(10);
        op(1'b0, 8'h00, 32'h0, 1'b1);
        check("clr_tx", 32'(tx), 32'h1);
        check("clr_busy", 32'(busy), 32'h0);
        idle(60);
        op(1'b0, 8'hFD, 32'h0, 1'b0);
        check("clr_div", rdata, 32'd16);

        // Random bus traffic with short divisors
        for (int i = 0; i < 2500; i++) begin
            r  = $urandom_range(0, 99);
            rv = $urandom;
            if (r < 2)       op(1'b0, pick_addr(), rv, 1'b1);
            else if (r < 25) op(1'b1, 8'hFF, rv, 1'b0);
            else if (r < 30) op(1'b1, 8'hFD, {rv[31:16], 16'(rv % 6)}, 1'b0);
            else if (r < 33) op(1'b1, 8'hFE, rv, 1'b0);
            else if (r < 36) op(1'b1, pick_addr(), rv, 1'b0);
            else             op(1'b0, pick_addr(), rv, 1'b0);
        end
        idle(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
